// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 2-digit common-segment 7-segment display.
// Latches the shown value only at frame boundaries, blanks each slot briefly, and decodes BCD to segments.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV     = 1024,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       C,
    input  logic       CLR,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic [1:0] dp_in,
    input  logic       blank_lz,
    output logic [7:0] seg,
    output logic [1:0] dig_en,
    output logic       frame_start
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef struct packed {
        logic [7:0] bcd;
        logic [1:0] dp;
        logic       lz;
    } disp_t;

    logic [CNT_W-1:0] slot_cnt;
    logic             digit;
    disp_t            disp;
    disp_t            pend;
    logic             pend_flag;

    logic             slot_wrap;
    logic             frame_bnd;
    logic             in_blank;
    logic [3:0]       nibble;
    logic [7:0]       seg_nxt;
    logic [1:0]       dig_nxt;
    logic             fs_nxt;
    disp_t            load_val;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign frame_bnd = slot_wrap && digit;
    assign in_blank  = (32'(slot_cnt) < BLANK_CYCLES);
    assign load_val  = '{bcd: bcd_in, dp: dp_in, lz: blank_lz};

    // Output pattern for the current (slot_cnt, digit); registered below.
    always_comb begin
        seg_nxt = '0;
        dig_nxt = '0;
        fs_nxt  = (slot_cnt == '0) && !digit;
        nibble  = digit ? disp.bcd[7:4] : disp.bcd[3:0];
        if (!in_blank) begin
            dig_nxt    = digit ? 2'b10 : 2'b01;
            seg_nxt[6:0] = (digit && disp.lz && (disp.bcd[7:4] == 4'd0)) ? 7'h00 : decode(nibble);
            seg_nxt[7] = disp.dp[digit];
        end
    end

    // Scan counters and registered outputs.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            slot_cnt    <= '0;
            digit       <= 1'b0;
            seg         <= '0;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            slot_cnt    <= slot_wrap ? '0 : slot_cnt + CNT_W'(1);
            if (slot_wrap) begin
                digit <= ~digit;
            end
            seg         <= seg_nxt;
            dig_en      <= dig_nxt;
            frame_start <= fs_nxt;
        end
    end

    // Frame-synchronous value latch; a load on the boundary itself bypasses pending.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            disp      <= '0;
            pend      <= '0;
            pend_flag <= 1'b0;
        end else if (load && frame_bnd) begin
            disp      <= load_val;
            pend_flag <= 1'b0;
        end else begin
            if (frame_bnd && pend_flag) begin
                disp      <= pend;
                pend_flag <= 1'b0;
            end
            if (load) begin
                pend      <= load_val;
                pend_flag <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the 2-digit BCD counter. Takes the counter's packed BCD value and drives a 2-digit common-segment 7-segment display by time multiplexing.
- Contains the BCD-to-segment decoder, digit scan timing and anti-ghosting blanking.
- Contains a frame-synchronous value latch, so a digit never changes mid-frame.

Parameters:
- SCAN_DIV, 1024: clock cycles per digit slot; legal range is BLANK_CYCLES+1 to 65535.
- BLANK_CYCLES, 16: cycles at the start of each slot with all digits and segments off (anti-ghosting); legal range is 0 to SCAN_DIV-1.

Ports:
- C  in  1  clock, rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- bcd_in  in  8  display value: [7:4] tens, [3:0] units.
- load  in  1  one-cycle strobe; capture bcd_in and dp_in.
- dp_in  in  2  decimal point per digit: [1] tens, [0] units.
- blank_lz  in  1  leading-zero blanking enable.
- seg  out  8  segment pattern Dgfedcba, active-high.
- dig_en  out  2  digit enable, one-hot active-high: [1] tens, [0] units.
- frame_start  out  1  one-cycle pulse at the start of every units slot.

Behaviour:
- Clock and reset: one clock, C. Reset CLR is asynchronous and active-high.
- CLR=1 sets all state immediately, regardless of C:
  - slot_cnt=0, digit=0 (units).
  - disp value=0x00, disp dp=0.
  - pending flag=0, pending value=0x00.
  - seg=0, dig_en=0, frame_start=0.
  - CLR asserted mid-slot or mid-frame aborts the scan. Scanning restarts at slot_cnt=0, digit=0 after CLR deasserts.
- Counters:
  - slot_cnt increments every cycle and wraps from SCAN_DIV-1 to 0.
  - digit toggles on each wrap.
  - A frame boundary is a wrap with digit going 1->0.
- Outputs are registered. They reflect (slot_cnt, digit) with 1-cycle latency.
  - While slot_cnt < BLANK_CYCLES: seg=0, dig_en=0.
  - Otherwise: dig_en = one-hot(digit), seg = decode(nibble) | (dp<<7).
- frame_start:
  - Registered; high for exactly the one output cycle in which slot_cnt=0 and digit=0.
  - This includes the first cycle after reset release.
- Decoder, nibble -> seg[6:0]:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles A-F (invalid BCD) show minus, 40.
- Leading-zero blanking: if blank_lz=1 and disp tens nibble=0, the tens slot still asserts dig_en[1], but seg[6:0]=0. The tens dp bit is still shown. Units are never blanked.
- Value latch:
  - load=1 captures bcd_in/dp_in into pending and sets the pending flag.
  - A later load before the boundary overwrites pending; the last load wins.
  - At a frame boundary with the pending flag set: disp <= pending, flag cleared. The new value is first visible in the units slot of that frame.
  - load in the same cycle as a frame boundary: the bcd_in/dp_in of that cycle transfer directly to disp, and the flag stays 0.
  - Without load, disp holds indefinitely.
- The block is free-running and has no backpressure. Inputs other than load are sampled only when load=1.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2 unless stated):
- Reset/scan: release CLR, no load.
  - Cycles 0-1: seg=00, dig_en=00.
  - Cycles 2-7: dig_en=01, seg=3F.
  - Cycles 8-9: blank.
  - Cycles 10-15: dig_en=10, seg=3F.
  - frame_start high at cycles 0 and 16 only.
- Frame-synchronous load: load bcd_in=0x47, dp_in=01 at cycle 5.
  - Cycles 5-15 still show 00.
  - From cycle 18: units seg=87.
  - From cycle 26: tens seg=66.
- Last load wins and boundary bypass:
  - load 0x12 at cycle 3, then 0x35 at cycle 9: frame 2 shows units 6D, tens 4F.
  - load 0x99 exactly in the boundary cycle: that same frame shows 6F/6F.
- Leading zero and invalid BCD:
  - disp=0x05, blank_lz=1: tens slot shows dig_en=10, seg=00.
  - Same value with blank_lz=0: tens seg=3F.
  - disp=0x0C: units seg=40.
- Reset mid-operation: with disp=0x47, assert CLR asynchronously during a tens slot (between edges).
  - seg, dig_en and frame_start go 0 immediately.
  - After release, scanning restarts at units with value 00.
- Blanking edge: BLANK_CYCLES=0, SCAN_DIV=1.
  - dig_en alternates 01/10 every cycle and is never 00.
  - frame_start pulses every 2 cycles.
